// File: rtl/wb_regfile_pipe_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_pipe_if
//   Bus bundle between the ex stage / id stage and the write-back register
//   file. Carries the ex result bus, pipeline control, both id read ports and
//   the mem_wb commit view.
//
//   master : the pipeline side (drives ex result, control, read requests)
//   slave  : wb_regfile_pipe (returns read data and the mem_wb stage)
//
//   wreg_i / waddr_i / wdata_i   ex result bus
//   stall_i[1:0]                 [0] hold ex_mem, [1] hold mem_wb
//   flush_i                      squash both stages
//   re1_i / raddr1_i / rdata1_o  read port 1
//   re2_i / raddr2_i / rdata2_o  read port 2
//   wb_wreg_o / wb_waddr_o / wb_wdata_o   mem_wb stage contents
// ---------------------------------------------------------------------------
interface wb_regfile_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wreg_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [1:0]        stall_i;
    logic              flush_i;
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic              wb_wreg_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic [DATA_W-1:0] wb_wdata_o;

    modport master (
        output wreg_i, waddr_i, wdata_i, stall_i, flush_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o, wb_wreg_o, wb_waddr_o, wb_wdata_o
    );

    modport slave (
        input  wreg_i, waddr_i, wdata_i, stall_i, flush_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o, wb_wreg_o, wb_waddr_o, wb_wdata_o
    );
endinterface

// File: rtl/wb_regfile_pipe.sv
// ---------------------------------------------------------------------------
// wb_regfile_pipe
//   Write-back end of a 5-stage pipeline. Ex results are carried through the
//   ex_mem and mem_wb stage registers and committed to a REG_NUM x DATA_W GPR
//   array. Two combinational id read ports forward the youngest in-flight
//   producer (ex, then ex_mem, then mem_wb) before falling back to the array.
//
//   clk  : pipeline clock, all state on the rising edge
//   rst  : synchronous reset, active-high
//   bus  : wb_regfile_pipe_if slave (ex result, stall/flush, read ports,
//          mem_wb view)
// ---------------------------------------------------------------------------
module wb_regfile_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_regfile_pipe_if.slave      bus
);

    typedef struct packed {
        logic              wreg;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t            r_ex_mem;
    stage_t            r_mem_wb;
    logic [DATA_W-1:0] r_gpr [REG_NUM];

    stage_t            w_ex;
    logic              w_commit;

    assign w_ex = '{wreg: bus.wreg_i, waddr: bus.waddr_i, wdata: bus.wdata_i};

    // mem_wb always holds an older, non-squashed instruction, so a flush in
    // the same cycle does not block its commit; only a mem_wb stall does.
    assign w_commit = r_mem_wb.wreg && (r_mem_wb.waddr != '0) && !bus.stall_i[1];

    // Stage advance: rst > flush > stall. A mem_wb stall always freezes
    // ex_mem too, so 2'b10 behaves as 2'b11.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others (mem_wb takes the old ex_mem).
        if (rst) begin
            r_ex_mem <= BUBBLE;
            r_mem_wb <= BUBBLE;
        end else if (bus.flush_i) begin
            r_ex_mem <= BUBBLE;
            r_mem_wb <= BUBBLE;
        end else if (bus.stall_i[1]) begin
            r_ex_mem <= r_ex_mem;
            r_mem_wb <= r_mem_wb;
        end else if (bus.stall_i[0]) begin
            r_ex_mem <= r_ex_mem;
            r_mem_wb <= BUBBLE;
        end else begin
            r_ex_mem <= w_ex;
            r_mem_wb <= r_ex_mem;
        end
    end

    // GPR array. Entry 0 is never written and therefore stays zero.
    always_ff @(posedge clk) begin
        // NOTE: the whole array is cleared on reset because software relies
        // on a zeroed register file; this forces it into flops, not RAM.
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_commit) begin
            r_gpr[r_mem_wb.waddr] <= r_mem_wb.wdata;
        end
    end

    // Read with forwarding, youngest producer first.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        logic [DATA_W-1:0] data;
        // NOTE: default first so every path assigns data; no latch inferred.
        data = '0;
        if (rst || !re || raddr == '0) begin
            data = '0;
        end else if (bus.wreg_i && bus.waddr_i == raddr) begin
            data = bus.wdata_i;
        end else if (r_ex_mem.wreg && r_ex_mem.waddr == raddr) begin
            data = r_ex_mem.wdata;
        end else if (r_mem_wb.wreg && r_mem_wb.waddr == raddr) begin
            data = r_mem_wb.wdata;
        end else begin
            data = r_gpr[raddr];
        end
        return data;
    endfunction

    always_comb begin
        bus.rdata1_o = read_port(bus.re1_i, bus.raddr1_i);
        bus.rdata2_o = read_port(bus.re2_i, bus.raddr2_i);
    end

    assign bus.wb_wreg_o  = r_mem_wb.wreg;
    assign bus.wb_waddr_o = r_mem_wb.waddr;
    assign bus.wb_wdata_o = r_mem_wb.wdata;

endmodule

// File: tb/tb_wb_regfile_pipe.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile_pipe
//   Self-checking bench for wb_regfile_pipe: directed write-back, forwarding,
//   zero-register, stall, flush and reset scenarios, then randomized traffic,
//   all compared against a behavioural model of the write-back pipeline.
// ---------------------------------------------------------------------------
module tb_wb_regfile_pipe;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_regfile_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    wb_regfile_pipe #(.DATA_W(DW), .ADDR_W(AW), .REG_NUM(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: an in-flight result is (valid, dest, value).
    typedef struct {
        bit          w;
        int          a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_em;
    ent_t        m_mw;
    logic [31:0] m_gpr [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t bubble();
        ent_t e;
        e.w = 1'b0;
        e.a = 0;
        e.d = '0;
        return e;
    endfunction

    function automatic ent_t ex_now();
        ent_t e;
        e.w = bus.wreg_i;
        e.a = int'(bus.waddr_i);
        e.d = bus.wdata_i;
        return e;
    endfunction

    // Youngest matching producer wins; register 0 and disabled ports read 0.
    function automatic logic [31:0] m_read(input bit re, input int a);
        ent_t src [3];
        if (rst || !re || a == 0) return '0;
        src[0] = ex_now();
        src[1] = m_em;
        src[2] = m_mw;
        foreach (src[i]) begin
            if (src[i].w && src[i].a == a) return src[i].d;
        end
        return m_gpr[a];
    endfunction

    task automatic m_reset();
        m_em = bubble();
        m_mw = bubble();
        foreach (m_gpr[i]) m_gpr[i] = '0;
    endtask

    task automatic m_edge();
        if (rst) begin
            m_reset();
        end else begin
            if (m_mw.w && m_mw.a != 0 && !bus.stall_i[1]) m_gpr[m_mw.a] = m_mw.d;
            if (bus.flush_i) begin
                m_em = bubble();
                m_mw = bubble();
            end else if (bus.stall_i[1]) begin
                m_em = m_em;
            end else if (bus.stall_i[0]) begin
                m_mw = bubble();
            end else begin
                m_mw = m_em;
                m_em = ex_now();
            end
        end
    endtask

    // Compare all outputs against the model, then take one clock edge.
    task automatic cyc();
        #1;
        check("rdata1", bus.rdata1_o, m_read(bus.re1_i, int'(bus.raddr1_i)));
        check("rdata2", bus.rdata2_o, m_read(bus.re2_i, int'(bus.raddr2_i)));
        check("wb_wreg", 32'(bus.wb_wreg_o), 32'(m_mw.w));
        check("wb_waddr", 32'(bus.wb_waddr_o), 32'(m_mw.a));
        check("wb_wdata", bus.wb_wdata_o, m_mw.d);
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic drive(input bit w, input int a, input logic [31:0] d);
        bus.wreg_i  = w;
        bus.waddr_i = a[4:0];
        bus.wdata_i = d;
    endtask

    initial begin
        int r;
        rst          = 1'b1;
        drive(0, 0, '0);
        bus.stall_i  = 2'b00;
        bus.flush_i  = 1'b0;
        bus.re1_i    = 1'b1;
        bus.raddr1_i = 5'd5;
        bus.re2_i    = 1'b0;
        bus.raddr2_i = '0;
        m_reset();

        // Reset state
        @(posedge clk);
        #1;
        check("rst_wb_wreg", 32'(bus.wb_wreg_o), 32'd0);
        check("rst_rdata1", bus.rdata1_o, 32'd0);
        cyc();
        rst = 1'b0;

        // Write-back: r5 visible from cycle 0 and after commit
        drive(1, 5, 32'h1234);
        #1;
        check("wb_fwd_ex", bus.rdata1_o, 32'h1234);
        cyc();
        drive(0, 0, '0);
        repeat (3) begin
            #1;
            check("wb_read_r5", bus.rdata1_o, 32'h1234);
            cyc();
        end

        // Forward priority: three writes to r3 in flight
        bus.re2_i    = 1'b1;
        bus.raddr2_i = 5'd3;
        drive(1, 3, 32'hAAAA_0001);
        cyc();
        drive(1, 3, 32'hBBBB_0002);
        cyc();
        drive(1, 3, 32'hCCCC_0003);
        #1;
        check("fwd_youngest", bus.rdata2_o, 32'hCCCC_0003);
        cyc();
        drive(0, 0, '0);
        repeat (3) begin
            #1;
            check("fwd_drain_r3", bus.rdata2_o, 32'hCCCC_0003);
            cyc();
        end

        // Zero register
        bus.raddr1_i = 5'd0;
        drive(1, 0, 32'hFFFF_FFFF);
        repeat (3) begin
            #1;
            check("zero_reg", bus.rdata1_o, 32'd0);
            cyc();
            drive(0, 0, '0);
        end

        // Stall 2'b01 with r7 in ex_mem
        bus.raddr1_i = 5'd7;
        drive(1, 7, 32'd9);
        cyc();
        drive(0, 0, '0);
        bus.stall_i = 2'b01;
        repeat (2) begin
            #1;
            check("stall_fwd_r7", bus.rdata1_o, 32'd9);
            cyc();
            check("stall_mw_bubble", 32'(bus.wb_wreg_o), 32'd0);
        end
        bus.stall_i = 2'b00;
        cyc();
        check("stall_rel_wreg", 32'(bus.wb_wreg_o), 32'd1);
        check("stall_rel_waddr", 32'(bus.wb_waddr_o), 32'd7);
        cyc();
        repeat (3) begin
            check("stall_once", 32'(bus.wb_wreg_o), 32'd0);
            #1;
            check("stall_gpr_r7", bus.rdata1_o, 32'd9);
            cyc();
        end

        // Flush: r9 in mem_wb commits, r8 in ex_mem is squashed
        drive(1, 9, 32'd4);
        cyc();
        drive(1, 8, 32'h88);
        cyc();
        drive(0, 0, '0);
        bus.flush_i = 1'b1;
        cyc();
        bus.flush_i  = 1'b0;
        bus.raddr1_i = 5'd9;
        bus.raddr2_i = 5'd8;
        #1;
        check("flush_commit_r9", bus.rdata1_o, 32'd4);
        check("flush_squash_r8", bus.rdata2_o, 32'd0);
        cyc();

        // Reset mid-stream
        drive(1, 5, 32'hABCD);
        cyc();
        drive(1, 6, 32'h66);
        cyc();
        rst = 1'b1;
        drive(1, 3, 32'h33);
        cyc();
        rst = 1'b0;
        drive(0, 0, '0);
        bus.raddr1_i = 5'd5;
        bus.raddr2_i = 5'd9;
        #1;
        check("rst_mid_wb_wreg", 32'(bus.wb_wreg_o), 32'd0);
        check("rst_mid_r5", bus.rdata1_o, 32'd0);
        check("rst_mid_r9", bus.rdata2_o, 32'd0);
        cyc();
        cyc();
        #1;
        check("rst_mid_no_commit", bus.rdata1_o, 32'd0);
        cyc();

        // Randomized traffic with narrow address range to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            rst         = ($urandom % 200 == 0);
            bus.flush_i = ($urandom % 25 == 0);
            r = int'($urandom % 10);
            bus.stall_i = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : (r == 2) ? 2'b10 : 2'b00;
            drive(($urandom % 4) != 0,
                  ($urandom % 5 == 0) ? int'($urandom % 32) : int'($urandom % 8),
                  $urandom);
            bus.re1_i    = ($urandom % 8) != 0;
            bus.raddr1_i = 5'($urandom % 8);
            bus.re2_i    = ($urandom % 8) != 0;
            bus.raddr2_i = ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 8);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
